// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: walks a synchronous program ROM, hands each
// instruction word (and, for mvi, its trailing immediate) to the processor,
// and waits for the processor to signal completion.
//
// Ports:
//   Clock, Resetn      rising-edge clock, asynchronous active-low reset
//   Start, Stop        begin/resume fetching; finish current instruction then idle
//   ADDR, MEM_Q        ROM address out, ROM data in (one-cycle read latency)
//   DIN, Run           instruction/immediate word and one-cycle launch strobe
//   Done               processor instruction-complete strobe
//   PC                 address of the next instruction
//   Busy/Halted/Error  status flags
//   InstrCount         completed-instruction count (wraps 255->0)
module inst_fetch_ctrl #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 6
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
  output logic [ADDR_W-1:0] ADDR,
  input  logic [8:0]        MEM_Q,
  output logic [8:0]        DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [7:0]        InstrCount
);

  // Counter only needs to reach TIMEOUT-1: the cycle at that value is the last one allowed.
  localparam int unsigned TmoW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [2:0] OpMvi  = 3'b001;
  localparam logic [2:0] OpHalt = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StExec,
    StHalted,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [7:0]        count_q, count_d;
  logic              mvi_q, mvi_d;
  logic              stop_pend_q, stop_pend_d;

  logic [2:0]        opcode;
  logic              exec_first;

  assign opcode     = MEM_Q[8:6];
  assign exec_first = (tmo_q == '0);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      tmo_q       <= '0;
      count_q     <= '0;
      mvi_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tmo_q       <= tmo_d;
      count_q     <= count_d;
      mvi_q       <= mvi_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tmo_d       = tmo_q;
    count_d     = count_q;
    mvi_d       = mvi_q;
    stop_pend_d = stop_pend_q;
    ADDR        = pc_q;
    DIN         = '0;
    Run         = 1'b0;

    case (state_q)
      StIdle: begin
        // Stop while idle means nothing; Start wins even if Stop is also high.
        stop_pend_d = 1'b0;
        if (Start) begin
          state_d = StFetch;
        end
      end

      StFetch: begin
        // Remember a Stop request so it takes effect at the next completion.
        if (Stop) begin
          stop_pend_d = 1'b1;
        end
        state_d = StIssue;
      end

      StIssue: begin
        if (Stop) begin
          stop_pend_d = 1'b1;
        end
        if (opcode == OpHalt) begin
          stop_pend_d = 1'b0;
          state_d     = StHalted;
        end else begin
          Run     = 1'b1;
          DIN     = MEM_Q;
          pc_d    = pc_q + 1'b1;
          mvi_d   = (opcode == OpMvi);
          tmo_d   = '0;
          state_d = StExec;
          // Pre-address the immediate so it arrives in the first EXEC cycle.
          if (opcode == OpMvi) begin
            ADDR = pc_q + 1'b1;
          end
        end
      end

      StExec: begin
        if (exec_first && mvi_q) begin
          DIN  = MEM_Q;
          pc_d = pc_q + 1'b1;
        end
        tmo_d = tmo_q + 1'b1;
        if (Done) begin
          count_d     = count_q + 1'b1;
          stop_pend_d = 1'b0;
          state_d     = (Stop || stop_pend_q) ? StIdle : StFetch;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          stop_pend_d = 1'b0;
          state_d     = StError;
        end else if (Stop) begin
          stop_pend_d = 1'b1;
        end
      end

      StHalted, StError: begin
        if (Start) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign PC         = pc_q;
  assign Busy       = (state_q == StFetch) || (state_q == StIssue) || (state_q == StExec);
  assign Halted     = (state_q == StHalted);
  assign Error      = (state_q == StError);
  assign InstrCount = count_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: a per-cycle vector table over a short program,
// directed sequences for timeout, PC wrap and mid-run reset, then a random
// program run against an instruction-level model of fetch/issue/complete.
module tb_inst_fetch_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned TMO = 6;

  localparam int ResFetch = 0;
  localparam int ResIdle  = 1;
  localparam int ResHalt  = 2;
  localparam int ResError = 3;

  logic          Clock;
  logic          Resetn;
  logic          Start;
  logic          Stop;
  logic [AW-1:0] ADDR;
  logic [8:0]    MEM_Q;
  logic [8:0]    DIN;
  logic          Run;
  logic          Done;
  logic [AW-1:0] PC;
  logic          Busy;
  logic          Halted;
  logic          Error;
  logic [7:0]    InstrCount;

  inst_fetch_ctrl #(
    .ADDR_W  (AW),
    .TIMEOUT (TMO)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Start      (Start),
    .Stop       (Stop),
    .ADDR       (ADDR),
    .MEM_Q      (MEM_Q),
    .DIN        (DIN),
    .Run        (Run),
    .Done       (Done),
    .PC         (PC),
    .Busy       (Busy),
    .Halted     (Halted),
    .Error      (Error),
    .InstrCount (InstrCount)
  );

  // Synchronous program ROM
  logic [8:0] rom [32];
  always @(posedge Clock) MEM_Q <= rom[ADDR];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction-level model state
  logic [AW-1:0] m_pc;
  logic [7:0]    m_cnt;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    Start  = 1'b0;
    Stop   = 1'b0;
    Done   = 1'b0;
    Resetn = 1'b0;
    tick();
    tick();
    Resetn = 1'b1;
    m_pc   = '0;
    m_cnt  = '0;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Runs one instruction from FETCH. dd = EXEC cycle carrying Done (>= TMO: never).
  // stop_at = phase with a one-cycle Stop (0 fetch, 1 issue, 2+k exec cycle k).
  task automatic run_instr(input int dd, input int stop_at, output int res);
    logic [8:0]    word;
    logic [8:0]    imm;
    logic [AW-1:0] ipc;
    logic [AW-1:0] nxt;
    bit            mvi;
    bit            stop_seen;
    bit            d;
    ipc       = m_pc;
    nxt       = ipc + 1'b1;
    word      = rom[ipc];
    imm       = rom[nxt];
    stop_seen = 1'b0;
    res       = ResError;

    Done  = 1'($urandom_range(0, 1));
    Start = 1'($urandom_range(0, 1));
    Stop  = (stop_at == 0);
    if (Stop) stop_seen = 1'b1;
    check("fetch_busy", Busy, 1);
    check("fetch_addr", ADDR, ipc);
    check("fetch_run", Run, 0);
    tick();

    Done  = 1'($urandom_range(0, 1));
    Start = 1'($urandom_range(0, 1));
    Stop  = (stop_at == 1);
    if (Stop) stop_seen = 1'b1;
    if (word[8:6] == 3'b111) begin
      check("halt_run", Run, 0);
      check("halt_addr", ADDR, ipc);
      tick();
      Start = 1'b0;
      Stop  = 1'b0;
      Done  = 1'b0;
      check("halt_flag", Halted, 1);
      check("halt_busy", Busy, 0);
      check("halt_pc", PC, ipc);
      check("halt_cnt", InstrCount, m_cnt);
      res = ResHalt;
      return;
    end
    mvi = (word[8:6] == 3'b001);
    check("issue_run", Run, 1);
    check("issue_din", DIN, word);
    check("issue_addr", ADDR, mvi ? nxt : ipc);
    tick();
    m_pc = nxt;

    for (int k = 0; k < int'(TMO); k++) begin
      d     = (k == dd);
      Done  = d;
      Start = 1'($urandom_range(0, 1));
      Stop  = (stop_at == k + 2);
      if (Stop) stop_seen = 1'b1;
      check("exec_run", Run, 0);
      check("exec_busy", Busy, 1);
      check("exec_pc", PC, m_pc);
      if (k == 0) check("exec_din", DIN, mvi ? imm : 9'h000);
      tick();
      if (k == 0 && mvi) m_pc = m_pc + 1'b1;
      if (d) begin
        m_cnt = m_cnt + 1'b1;
        res   = stop_seen ? ResIdle : ResFetch;
        break;
      end
    end
    Start = 1'b0;
    Stop  = 1'b0;
    Done  = 1'b0;
    if (res == ResError) begin
      check("tmo_error", Error, 1);
      check("tmo_busy", Busy, 0);
      check("tmo_cnt", InstrCount, m_cnt);
    end
  endtask

  typedef struct {
    logic       start;
    logic       stop;
    logic       done;
    logic       run;
    logic [8:0] din;
    logic [4:0] addr;
    logic [4:0] pc;
    logic       busy;
    logic       halted;
    logic       error;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [23];

  initial begin
    int res;

    // Program: mv, mvi #1A5, add, halt
    for (int i = 0; i < 32; i++) rom[i] = 9'h000;
    rom[0] = 9'b000_001_010;
    rom[1] = 9'b001_011_000;
    rom[2] = 9'h1A5;
    rom[3] = 9'b010_000_001;
    rom[4] = 9'b111_000_000;

    //            start stop done  run  din     addr pc  busy halt err cnt
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h000, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 9'h00A, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 9'h058, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h1A5, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'h081, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 8'd3};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 8'd3};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 8'd3};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 5'd4, 5'd4, 1'b0, 1'b1, 1'b0, 8'd3};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 5'd4, 5'd4, 1'b0, 1'b1, 1'b0, 8'd3};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 8'd3};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'h00A, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 8'd3};

    do_reset();
    for (int i = 0; i < 23; i++) begin
      Start = vecs[i].start;
      Stop  = vecs[i].stop;
      Done  = vecs[i].done;
      check($sformatf("v%0d_run", i), Run, vecs[i].run);
      check($sformatf("v%0d_din", i), DIN, vecs[i].din);
      check($sformatf("v%0d_addr", i), ADDR, vecs[i].addr);
      check($sformatf("v%0d_pc", i), PC, vecs[i].pc);
      check($sformatf("v%0d_busy", i), Busy, vecs[i].busy);
      check($sformatf("v%0d_halted", i), Halted, vecs[i].halted);
      check($sformatf("v%0d_error", i), Error, vecs[i].error);
      check($sformatf("v%0d_cnt", i), InstrCount, vecs[i].cnt);
      tick();
    end

    // Timeout: opcode 101 never completes
    do_reset();
    rom[0] = 9'b101_000_000;
    start_pulse();
    tick();
    check("to_run", Run, 1);
    tick();
    for (int k = 0; k < int'(TMO); k++) begin
      check("to_wait_err", Error, 0);
      check("to_wait_busy", Busy, 1);
      tick();
    end
    check("to_err", Error, 1);
    check("to_busy", Busy, 0);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    check("to_late_done_cnt", InstrCount, 0);
    check("to_sticky", Error, 1);
    start_pulse();
    check("to_clear", Error, 0);
    check("to_addr", ADDR, 0);
    check("to_rebusy", Busy, 1);

    // Reset in the middle of an add
    do_reset();
    rom[0] = 9'b010_000_001;
    start_pulse();
    tick();
    check("rst_run", Run, 1);
    tick();
    tick();
    Resetn = 1'b0;
    #1;
    check("rst_pc", PC, 0);
    check("rst_addr", ADDR, 0);
    check("rst_din", DIN, 0);
    check("rst_run0", Run, 0);
    check("rst_busy", Busy, 0);
    check("rst_halt", Halted, 0);
    check("rst_err", Error, 0);
    check("rst_cnt", InstrCount, 0);
    Done = 1'b1;
    tick();
    Resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_idle_busy", Busy, 0);
      check("rst_idle_run", Run, 0);
      check("rst_idle_cnt", InstrCount, 0);
    end
    Done = 1'b0;
    start_pulse();
    check("rst_resume_busy", Busy, 1);
    check("rst_resume_addr", ADDR, 0);

    // mvi at the last address takes its immediate from address 0
    do_reset();
    rom[0] = 9'b000_111_011;
    for (int i = 1; i < 31; i++) rom[i] = 9'b000_001_010;
    rom[31] = 9'b001_011_000;
    start_pulse();
    for (int n = 0; n < 32; n++) run_instr(0, 99, res);
    check("wrap_pc", PC, 1);
    check("wrap_cnt", InstrCount, 32);

    // Random program against the instruction-level model
    do_reset();
    for (int i = 0; i < 32; i++) rom[i] = 9'($urandom);
    start_pulse();
    for (int n = 0; n < 400; n++) begin
      int dd;
      dd = ($urandom_range(0, 7) == 0) ? int'(TMO) : int'($urandom_range(0, TMO - 1));
      run_instr(dd, int'($urandom_range(0, 12)), res);
      if (res == ResIdle) begin
        check("r_idle_busy", Busy, 0);
        check("r_idle_pc", PC, m_pc);
        check("r_idle_cnt", InstrCount, m_cnt);
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
          Stop = 1'($urandom_range(0, 1));
          Done = 1'($urandom_range(0, 1));
          tick();
          check("r_idle_hold", Busy, 0);
          check("r_idle_norun", Run, 0);
        end
        Done  = 1'b0;
        Stop  = 1'($urandom_range(0, 1));
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Stop  = 1'b0;
      end else if (res == ResHalt || res == ResError) begin
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
          Done = 1'($urandom_range(0, 1));
          tick();
          check("r_sticky", Halted | Error, 1);
          check("r_sticky_cnt", InstrCount, m_cnt);
        end
        Done = 1'b0;
        start_pulse();
        m_pc = '0;
        check("r_restart_halt", Halted, 0);
        check("r_restart_err", Error, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
